// File: rtl/hbridge_pwm_if.sv
// Command/status bundle for the H-bridge PWM block: per-channel duty/dir/mode
// with a load strobe in, registered bridge drives and period marker out.
interface hbridge_pwm_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 8
);
  logic [N_CH-1:0][CNT_W-1:0] duty;
  logic [N_CH-1:0]            dir;
  logic [N_CH-1:0][1:0]       mode;
  logic                       load;
  logic [N_CH-1:0]            out_a;
  logic [N_CH-1:0]            out_b;
  logic                       period_start;

  modport master (output duty, dir, mode, load, input out_a, out_b, period_start);
  modport slave  (input duty, dir, mode, load, output out_a, out_b, period_start);
endinterface

// File: rtl/hbridge_pwm.sv
// Multi-channel H-bridge PWM: shared prescaler/period counter, per-channel
// double-buffered settings and a dead-time FSM guarding dir/mode changes.
module hbridge_pwm_ch #(
  parameter int CNT_W    = 8,
  parameter int DEAD_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             wrap,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic             dir,
  input  logic [1:0]       mode,
  output logic             out_a,
  output logic             out_b
);
  localparam int DC_W = $clog2(DEAD_CYC + 1);

  typedef enum logic {RUN, DEAD} st_t;
  st_t st, st_nx;
  logic [DC_W-1:0]  dcnt, dcnt_nx;
  logic [CNT_W-1:0] pend_duty, act_duty;
  logic             pend_dir, act_dir;
  logic [1:0]       pend_mode, act_mode;
  logic             chg, pwm_on, a_nx, b_nx;

  assign chg = wrap && ((pend_dir != act_dir) || (pend_mode != act_mode));
  // counter never exceeds PERIOD-1, so duty >= PERIOD saturates to always-on
  assign pwm_on = (cnt < act_duty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_duty <= '0; pend_dir <= 1'b0; pend_mode <= 2'b00;
      act_duty  <= '0; act_dir  <= 1'b0; act_mode  <= 2'b00;
    end else begin
      if (load) begin
        pend_duty <= duty; pend_dir <= dir; pend_mode <= mode;
      end
      if (wrap) begin
        act_duty <= pend_duty; act_dir <= pend_dir; act_mode <= pend_mode;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= RUN; dcnt <= '0; out_a <= 1'b0; out_b <= 1'b0;
    end else begin
      st <= st_nx; dcnt <= dcnt_nx; out_a <= a_nx; out_b <= b_nx;
    end
  end

  // The wrap edge itself is the first blanked cycle; DEAD covers the rest.
  always_comb begin
    st_nx   = st;
    dcnt_nx = dcnt;
    a_nx    = 1'b0;
    b_nx    = 1'b0;
    if (chg) begin
      st_nx   = (DEAD_CYC > 1) ? DEAD : RUN;
      dcnt_nx = DC_W'(DEAD_CYC - 1);
    end else if (st == DEAD) begin
      if (dcnt <= DC_W'(1)) st_nx = RUN;
      dcnt_nx = dcnt - DC_W'(1);
    end
    if (!chg && st == RUN) begin
      case (act_mode)
        2'b01:   begin a_nx = ~act_dir & pwm_on; b_nx = act_dir & pwm_on; end
        2'b10:   begin a_nx = 1'b1; b_nx = 1'b1; end
        default: begin a_nx = 1'b0; b_nx = 1'b0; end
      endcase
    end
  end
endmodule

module hbridge_pwm #(
  parameter int N_CH     = 2,
  parameter int CNT_W    = 8,
  parameter int PERIOD   = 100,
  parameter int DIV      = 10,
  parameter int DEAD_CYC = 4
) (
  input logic          clk,
  input logic          rst_n,
  hbridge_pwm_if.slave bus
);
  localparam int               PRE_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PERIOD - 1);

  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] cnt;
  logic             tick, wrap, ps_q;
  logic [N_CH-1:0]  out_a, out_b;

  assign tick = (pre == PRE_MAX);
  assign wrap = tick && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre  <= '0;
      cnt  <= '0;
      ps_q <= 1'b0;
    end else begin
      pre  <= tick ? '0 : pre + PRE_W'(1);
      if (tick) cnt <= wrap ? '0 : cnt + CNT_W'(1);
      ps_q <= wrap;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    hbridge_pwm_ch #(.CNT_W(CNT_W), .DEAD_CYC(DEAD_CYC)) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (bus.load),
      .wrap  (wrap),
      .cnt   (cnt),
      .duty  (bus.duty[g]),
      .dir   (bus.dir[g]),
      .mode  (bus.mode[g]),
      .out_a (out_a[g]),
      .out_b (out_b[g])
    );
  end

  assign bus.out_a        = out_a;
  assign bus.out_b        = out_b;
  assign bus.period_start = ps_q;
endmodule

// File: tb/tb_hbridge_pwm.sv
// Randomized scoreboard bench: a time-arithmetic reference model queues the
// expected outputs of every clock edge, a monitor pops and compares them.
module tb_hbridge_pwm;
  localparam int N_CH = 2, CNT_W = 8, PERIOD = 10, DIV = 2, DEAD_CYC = 3;
  localparam int FRAME = DIV * PERIOD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  hbridge_pwm_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus();

  hbridge_pwm #(.N_CH(N_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .DIV(DIV),
                .DEAD_CYC(DEAD_CYC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [N_CH-1:0] a;
    logic [N_CH-1:0] b;
    logic            ps;
    int              k;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  int k = 0;
  int pd[N_CH], pm[N_CH], pdir[N_CH];
  int ad[N_CH], am[N_CH], adir[N_CH];
  int dead_until[N_CH];

  task automatic chk(input string nm, input int kk, input logic [2*N_CH:0] got,
                     input logic [2*N_CH:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge=%0d got {a,b,ps}=%b expected %b", nm, kk, got, exp);
  endtask

  function automatic logic [1:0] ref_ab(input int m, input int d, input int du, input int c);
    int  eff;
    logic on;
    eff = (du < PERIOD) ? du : PERIOD;
    on  = (c < eff);
    case (m)
      1:       return d ? {1'b0, on} : {on, 1'b0};
      2:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Reference model: edge k after reset release; ticks land on multiples of
  // DIV, wraps on multiples of DIV*PERIOD.
  initial begin
    exp_t e;
    int c;
    logic wr;
    logic [1:0] ab;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        k = 0;
        q.delete();
        for (int i = 0; i < N_CH; i++) begin
          pd[i] = 0; pm[i] = 0; pdir[i] = 0;
          ad[i] = 0; am[i] = 0; adir[i] = 0;
          dead_until[i] = 0;
        end
      end else begin
        k++;
        c  = ((k - 1) / DIV) % PERIOD;
        wr = ((k % FRAME) == 0);
        e.k = k; e.ps = wr; e.a = '0; e.b = '0;
        for (int i = 0; i < N_CH; i++) begin
          if (wr && (pdir[i] != adir[i] || pm[i] != am[i]))
            dead_until[i] = k + DEAD_CYC - 1;
          ab = ref_ab(am[i], adir[i], ad[i], c);
          if (k <= dead_until[i]) ab = 2'b00;
          e.a[i] = ab[1];
          e.b[i] = ab[0];
        end
        if (wr)
          for (int i = 0; i < N_CH; i++) begin
            ad[i] = pd[i]; am[i] = pm[i]; adir[i] = pdir[i];
          end
        if (bus.load)
          for (int i = 0; i < N_CH; i++) begin
            pd[i] = int'(bus.duty[i]); pm[i] = int'(bus.mode[i]); pdir[i] = int'(bus.dir[i]);
          end
        q.push_back(e);
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n)
        chk("rst_hold", k, {bus.out_a, bus.out_b, bus.period_start}, '0);
      else if (q.size() > 0) begin
        e = q.pop_front();
        chk("outputs", e.k, {bus.out_a, bus.out_b, bus.period_start}, {e.a, e.b, e.ps});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_load();
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask

  task automatic set_ch(input int ch, input int du, input int d, input int m);
    bus.duty[ch] = CNT_W'(du);
    bus.dir[ch]  = d[0];
    bus.mode[ch] = m[1:0];
  endtask

  // position so that the next posedge is a wrap edge
  task automatic to_wrap_edge();
    while (((k + 1) % FRAME) != 0) step(1);
  endtask

  task automatic rand_load();
    int sel;
    for (int i = 0; i < N_CH; i++) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0: set_ch(i, 0, $urandom_range(0, 1), $urandom_range(0, 3));
        1: set_ch(i, PERIOD, $urandom_range(0, 1), $urandom_range(0, 3));
        2: set_ch(i, 255, $urandom_range(0, 1), $urandom_range(0, 3));
        default: set_ch(i, $urandom_range(0, PERIOD + 1), $urandom_range(0, 1), $urandom_range(0, 3));
      endcase
    end
    if ($urandom_range(0, 3) == 0) to_wrap_edge();
    do_load();
  endtask

  initial begin
    bus.duty = '0; bus.dir = '0; bus.mode = '0; bus.load = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step(30);

    set_ch(0, 4, 0, 1); set_ch(1, 0, 0, 0); do_load(); step(3 * FRAME);
    set_ch(0, 0, 0, 1);   do_load(); step(2 * FRAME);
    set_ch(0, 10, 0, 1);  do_load(); step(2 * FRAME);
    set_ch(0, 255, 0, 1); do_load(); step(2 * FRAME);
    set_ch(0, 5, 1, 1);   do_load(); step(3 * FRAME);

    while ((k % FRAME) != FRAME / 2) step(1);
    set_ch(0, 2, 1, 1); do_load();
    to_wrap_edge();
    set_ch(0, 7, 1, 1); do_load();
    step(3 * FRAME);

    set_ch(1, 3, 0, 2); do_load(); step(3 * FRAME);

    repeat (60) begin
      step($urandom_range(1, 25));
      rand_load();
    end

    // reset right after a dir change wrap, with ch1 braking
    set_ch(0, 8, 0, 1); set_ch(1, 0, 0, 2); do_load();
    to_wrap_edge(); step(FRAME);
    set_ch(0, 8, 1, 1); do_load();
    to_wrap_edge(); step(2);
    #1 rst_n = 1'b0;
    #1 chk("rst_async", k, {bus.out_a, bus.out_b, bus.period_start}, '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    step(2 * FRAME);

    repeat (30) begin
      step($urandom_range(1, 25));
      rand_load();
    end
    step(2 * FRAME);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
